// File: rtl/change_dispenser.sv
// Greedy coin payout: turns a change amount into timed single-coin eject
// pulses, skipping empty hoppers and reporting any unpayable remainder.
module change_dispenser #(
    parameter int PULSE_CYCLES = 1000,
    parameter int GAP_CYCLES   = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [9:0] amount,
    input  logic       dollar_empty,
    input  logic       quarter_empty,
    input  logic       dime_empty,
    input  logic       nickel_empty,
    output logic       ready,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [9:0] short_amount,
    output logic       dollar_out,
    output logic       quarter_out,
    output logic       dime_out,
    output logic       nickel_out
);

    localparam int MAXC = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(MAXC) + 1;
    localparam logic [CW-1:0] P_LAST = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] G_LAST = CW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        PULSE,
        GAP,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [9:0]    rem_q, rem_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    coin_q, coin_d;
    logic [3:0]    out_q, out_d;
    logic          ready_q, ready_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic [9:0]    short_q, short_d;

    logic [3:0]    avail;
    logic [3:0]    pick;
    logic [9:0]    coin_val;

    // Bit order {dollar, quarter, dime, nickel}; highest eligible bit wins.
    always_comb begin
        avail[3] = !dollar_empty  && (rem_q >= 10'd100);
        avail[2] = !quarter_empty && (rem_q >= 10'd25);
        avail[1] = !dime_empty    && (rem_q >= 10'd10);
        avail[0] = !nickel_empty  && (rem_q >= 10'd5);
        pick = 4'b0000;
        if (avail[3])      pick = 4'b1000;
        else if (avail[2]) pick = 4'b0100;
        else if (avail[1]) pick = 4'b0010;
        else if (avail[0]) pick = 4'b0001;
    end

    always_comb begin
        coin_val = 10'd0;
        unique case (1'b1)
            coin_q[3]: coin_val = 10'd100;
            coin_q[2]: coin_val = 10'd25;
            coin_q[1]: coin_val = 10'd10;
            coin_q[0]: coin_val = 10'd5;
            default:   coin_val = 10'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        coin_d  = coin_q;
        out_d   = out_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        error_d = error_q;
        short_d = short_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SELECT;
                    rem_d   = amount;
                    error_d = 1'b0;
                    short_d = 10'd0;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            SELECT: begin
                if (rem_q == 10'd0) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else if (pick == 4'b0000) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    error_d = 1'b1;
                    short_d = rem_q;
                end else begin
                    state_d = PULSE;
                    coin_d  = pick;
                    out_d   = pick;
                    cnt_d   = '0;
                end
            end
            PULSE: begin
                if (cnt_q == P_LAST) begin
                    state_d = GAP;
                    rem_d   = rem_q - coin_val;
                    out_d   = 4'b0000;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == G_LAST) begin
                    state_d = SELECT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                out_d   = 4'b0000;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= 10'd0;
            cnt_q   <= '0;
            coin_q  <= 4'b0000;
            out_q   <= 4'b0000;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            short_q <= 10'd0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            coin_q  <= coin_d;
            out_q   <= out_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
            short_q <= short_d;
        end
    end

    assign ready        = ready_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign short_amount = short_q;
    assign dollar_out   = out_q[3];
    assign quarter_out  = out_q[2];
    assign dime_out     = out_q[1];
    assign nickel_out   = out_q[0];

endmodule
